// File: rtl/bus_arbiter.sv
// Common-bus arbiter: round-robin processor-side grant group and
// fixed-priority snoop-side grant group, both with registered grants.
module bus_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic Com_Bus_Req_proc_0,
    input  logic Com_Bus_Req_proc_1,
    input  logic Com_Bus_Req_proc_2,
    input  logic Com_Bus_Req_proc_3,
    input  logic Com_Bus_Req_proc_4,
    input  logic Com_Bus_Req_proc_5,
    input  logic Com_Bus_Req_proc_6,
    input  logic Com_Bus_Req_proc_7,
    input  logic Com_Bus_Req_snoop_0,
    input  logic Com_Bus_Req_snoop_1,
    input  logic Com_Bus_Req_snoop_2,
    input  logic Com_Bus_Req_snoop_3,
    input  logic Mem_snoop_req,
    output logic Com_Bus_Gnt_proc_0,
    output logic Com_Bus_Gnt_proc_1,
    output logic Com_Bus_Gnt_proc_2,
    output logic Com_Bus_Gnt_proc_3,
    output logic Com_Bus_Gnt_proc_4,
    output logic Com_Bus_Gnt_proc_5,
    output logic Com_Bus_Gnt_proc_6,
    output logic Com_Bus_Gnt_proc_7,
    output logic Com_Bus_Gnt_snoop_0,
    output logic Com_Bus_Gnt_snoop_1,
    output logic Com_Bus_Gnt_snoop_2,
    output logic Com_Bus_Gnt_snoop_3,
    output logic Mem_snoop_gnt
);

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    // Request vectors; snoop index 4 is the memory requester.
    logic [7:0] preq;
    logic [4:0] sreq;

    assign preq = {Com_Bus_Req_proc_7, Com_Bus_Req_proc_6,
                   Com_Bus_Req_proc_5, Com_Bus_Req_proc_4,
                   Com_Bus_Req_proc_3, Com_Bus_Req_proc_2,
                   Com_Bus_Req_proc_1, Com_Bus_Req_proc_0};

    assign sreq = {Mem_snoop_req,
                   Com_Bus_Req_snoop_3, Com_Bus_Req_snoop_2,
                   Com_Bus_Req_snoop_1, Com_Bus_Req_snoop_0};

    // ---------------- processor group ----------------
    arb_state_e pstate_q, pstate_d;
    logic [2:0] powner_q, powner_d;
    logic [2:0] pptr_q, pptr_d;
    logic [7:0] pgnt_q, pgnt_d;
    logic [2:0] pwin;
    logic [2:0] pcand;
    logic       pany;

    // Round-robin search starting just after the last granted index
    always_comb begin
        pwin  = pptr_q;
        pcand = pptr_q;
        pany  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            pcand = pptr_q + 3'(k);
            if (!pany && preq[pcand]) begin
                pwin = pcand;
                pany = 1'b1;
            end
        end
    end

    // Processor FSM next state: grant on arbitration, hold until release
    always_comb begin
        pstate_d = pstate_q;
        powner_d = powner_q;
        pptr_d   = pptr_q;
        pgnt_d   = pgnt_q;
        unique case (pstate_q)
            ARB_IDLE: begin
                if (pany) begin
                    pstate_d = ARB_GRANT;
                    powner_d = pwin;
                    pptr_d   = pwin;
                    pgnt_d   = 8'b1 << pwin;
                end
            end
            ARB_GRANT: begin
                if (!preq[powner_q]) begin
                    pstate_d = ARB_IDLE;
                    pgnt_d   = '0;
                end
            end
            default: begin
                pstate_d = ARB_IDLE;
                pgnt_d   = '0;
            end
        endcase
    end

    // Processor state register; pointer resets to 7 so proc_0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            pstate_q <= ARB_IDLE;
            powner_q <= 3'd0;
            pptr_q   <= 3'd7;
            pgnt_q   <= '0;
        end else begin
            pstate_q <= pstate_d;
            powner_q <= powner_d;
            pptr_q   <= pptr_d;
            pgnt_q   <= pgnt_d;
        end
    end

    // ---------------- snoop group ----------------
    arb_state_e sstate_q, sstate_d;
    logic [2:0] sowner_q, sowner_d;
    logic [4:0] sgnt_q, sgnt_d;
    logic [2:0] swin;
    logic       sany;

    // Fixed priority: lowest index wins, memory (index 4) last
    always_comb begin
        swin = 3'd0;
        sany = |sreq;
        for (int k = 4; k >= 0; k--) begin
            if (sreq[k]) begin
                swin = 3'(k);
            end
        end
    end

    // Snoop FSM next state: same hold/release rules as processor group
    always_comb begin
        sstate_d = sstate_q;
        sowner_d = sowner_q;
        sgnt_d   = sgnt_q;
        unique case (sstate_q)
            ARB_IDLE: begin
                if (sany) begin
                    sstate_d = ARB_GRANT;
                    sowner_d = swin;
                    sgnt_d   = 5'b1 << swin;
                end
            end
            ARB_GRANT: begin
                if (!sreq[sowner_q]) begin
                    sstate_d = ARB_IDLE;
                    sgnt_d   = '0;
                end
            end
            default: begin
                sstate_d = ARB_IDLE;
                sgnt_d   = '0;
            end
        endcase
    end

    // Snoop state register
    always_ff @(posedge clk) begin
        if (rst) begin
            sstate_q <= ARB_IDLE;
            sowner_q <= 3'd0;
            sgnt_q   <= '0;
        end else begin
            sstate_q <= sstate_d;
            sowner_q <= sowner_d;
            sgnt_q   <= sgnt_d;
        end
    end

    assign Com_Bus_Gnt_proc_0  = pgnt_q[0];
    assign Com_Bus_Gnt_proc_1  = pgnt_q[1];
    assign Com_Bus_Gnt_proc_2  = pgnt_q[2];
    assign Com_Bus_Gnt_proc_3  = pgnt_q[3];
    assign Com_Bus_Gnt_proc_4  = pgnt_q[4];
    assign Com_Bus_Gnt_proc_5  = pgnt_q[5];
    assign Com_Bus_Gnt_proc_6  = pgnt_q[6];
    assign Com_Bus_Gnt_proc_7  = pgnt_q[7];
    assign Com_Bus_Gnt_snoop_0 = sgnt_q[0];
    assign Com_Bus_Gnt_snoop_1 = sgnt_q[1];
    assign Com_Bus_Gnt_snoop_2 = sgnt_q[2];
    assign Com_Bus_Gnt_snoop_3 = sgnt_q[3];
    assign Mem_snoop_gnt       = sgnt_q[4];

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus
// randomized traffic against a behavioural arbitration model.
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req_p;
    logic [3:0] req_s;
    logic       req_m;
    logic [7:0] gnt_p;
    logic [3:0] gnt_s;
    logic       gnt_m;

    int total;
    int bad;

    // Model: owner index or -1 when idle, last proc winner
    int m_pown;
    int m_last;
    int m_sown;

    bus_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .Com_Bus_Req_proc_0  (req_p[0]),
        .Com_Bus_Req_proc_1  (req_p[1]),
        .Com_Bus_Req_proc_2  (req_p[2]),
        .Com_Bus_Req_proc_3  (req_p[3]),
        .Com_Bus_Req_proc_4  (req_p[4]),
        .Com_Bus_Req_proc_5  (req_p[5]),
        .Com_Bus_Req_proc_6  (req_p[6]),
        .Com_Bus_Req_proc_7  (req_p[7]),
        .Com_Bus_Req_snoop_0 (req_s[0]),
        .Com_Bus_Req_snoop_1 (req_s[1]),
        .Com_Bus_Req_snoop_2 (req_s[2]),
        .Com_Bus_Req_snoop_3 (req_s[3]),
        .Mem_snoop_req       (req_m),
        .Com_Bus_Gnt_proc_0  (gnt_p[0]),
        .Com_Bus_Gnt_proc_1  (gnt_p[1]),
        .Com_Bus_Gnt_proc_2  (gnt_p[2]),
        .Com_Bus_Gnt_proc_3  (gnt_p[3]),
        .Com_Bus_Gnt_proc_4  (gnt_p[4]),
        .Com_Bus_Gnt_proc_5  (gnt_p[5]),
        .Com_Bus_Gnt_proc_6  (gnt_p[6]),
        .Com_Bus_Gnt_proc_7  (gnt_p[7]),
        .Com_Bus_Gnt_snoop_0 (gnt_s[0]),
        .Com_Bus_Gnt_snoop_1 (gnt_s[1]),
        .Com_Bus_Gnt_snoop_2 (gnt_s[2]),
        .Com_Bus_Gnt_snoop_3 (gnt_s[3]),
        .Mem_snoop_gnt       (gnt_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] exp_p();
        return (m_pown < 0) ? 8'h00 : 8'(1 << m_pown);
    endfunction

    function automatic logic [4:0] exp_s();
        return (m_sown < 0) ? 5'h00 : 5'(1 << m_sown);
    endfunction

    // Model of one rising edge using the request levels present at it
    task automatic model_edge();
        logic [4:0] sr;
        sr = {req_m, req_s};
        if (rst) begin
            m_pown = -1;
            m_last = 7;
            m_sown = -1;
            return;
        end
        if (m_pown >= 0) begin
            if (!req_p[m_pown]) m_pown = -1;
        end else begin
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_last + k) % 8;
                if (req_p[c]) begin
                    m_pown = c;
                    m_last = c;
                    break;
                end
            end
        end
        if (m_sown >= 0) begin
            if (!sr[m_sown]) m_sown = -1;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sr[i]) begin
                    m_sown = i;
                    break;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        req_p = '0;
        req_s = '0;
        req_m = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // One-hot-or-zero on both groups every cycle
    always @(negedge clk) begin
        total++;
        if (!$onehot0(gnt_p)) begin
            bad++;
            $display("FAIL onehot_proc got=%b need one-hot-or-zero", gnt_p);
        end
        total++;
        if (!$onehot0({gnt_m, gnt_s})) begin
            bad++;
            $display("FAIL onehot_snoop got=%b need one-hot-or-zero",
                     {gnt_m, gnt_s});
        end
    end

    task automatic test_reset();
        rst   = 1'b1;
        req_p = 8'hFF;
        req_s = 4'hF;
        req_m = 1'b1;
        step();
        step();
        total++;
        if ({gnt_p, gnt_s, gnt_m} !== 13'h0) begin
            bad++;
            $display("FAIL reset_grants got=%h need 0", {gnt_p, gnt_s, gnt_m});
        end
        rst   = 1'b0;
        req_p = '0;
        req_s = '0;
        req_m = 1'b0;
        step();
        total++;
        if ({gnt_p, gnt_s, gnt_m} !== 13'h0) begin
            bad++;
            $display("FAIL reset_idle got=%h need 0", {gnt_p, gnt_s, gnt_m});
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_p = 8'h01;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (gnt_p !== 8'h01) begin
                bad++;
                $display("FAIL single_hold cyc=%0d got=%h need 01", i, gnt_p);
            end
        end
        req_p = 8'h00;
        step();
        total++;
        if (gnt_p !== 8'h00) begin
            bad++;
            $display("FAIL single_release got=%h need 00", gnt_p);
        end
    endtask

    task automatic test_round_robin();
        int         seq[$];
        logic [7:0] prev;
        int         held;
        apply_reset();
        prev  = '0;
        held  = 0;
        req_p = 8'h89;
        for (int cyc = 0; cyc < 12; cyc++) begin
            step();
            total++;
            if (gnt_p !== exp_p()) begin
                bad++;
                $display("FAIL rr_model cyc=%0d got=%h need %h",
                         cyc, gnt_p, exp_p());
            end
            if (gnt_p != 0 && gnt_p != prev) seq.push_back($clog2(gnt_p));
            held = (gnt_p == 0) ? 0 : ((gnt_p == prev) ? held + 1 : 1);
            if (held == 2) req_p = req_p & ~gnt_p;
            else if (gnt_p == 0) req_p = 8'h89;
            prev = gnt_p;
        end
        total++;
        if (seq.size() < 4) begin
            bad++;
            $display("FAIL rr_count got=%0d need >=4", seq.size());
        end else if (seq[0] != 0 || seq[1] != 3 || seq[2] != 7 || seq[3] != 0) begin
            bad++;
            $display("FAIL rr_order got=%0d,%0d,%0d,%0d need 0,3,7,0",
                     seq[0], seq[1], seq[2], seq[3]);
        end
        req_p = '0;
    endtask

    task automatic test_snoop_priority();
        logic [4:0] need [6];
        need = '{5'b00100, 5'b00100, 5'b00000,
                 5'b00001, 5'b00000, 5'b10000};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin req_s = 4'b0100; req_m = 1'b1; end
                1: req_s = 4'b0101;
                2: req_s = 4'b0001;
                4: req_s = 4'b0000;
                default: ;
            endcase
            step();
            total++;
            if ({gnt_m, gnt_s} !== need[i] || {gnt_m, gnt_s} !== exp_s()) begin
                bad++;
                $display("FAIL snoop_prio step=%0d got=%b need %b model %b",
                         i, {gnt_m, gnt_s}, need[i], exp_s());
            end
        end
        req_m = 1'b0;
        step();
    endtask

    task automatic test_concurrent();
        apply_reset();
        req_p = 8'h20;
        req_s = 4'b0010;
        step();
        total++;
        if (gnt_p !== 8'h20 || gnt_s !== 4'b0010 || gnt_m !== 1'b0) begin
            bad++;
            $display("FAIL concurrent got=%h/%b need 20/0010", gnt_p, gnt_s);
        end
        req_p = '0;
        req_s = '0;
        step();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_p = 8'h10;
        step();
        total++;
        if (gnt_p !== 8'h10) begin
            bad++;
            $display("FAIL rstmid_grant got=%h need 10", gnt_p);
        end
        rst = 1'b1;
        step();
        total++;
        if (gnt_p !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_clear got=%h need 00", gnt_p);
        end
        rst   = 1'b0;
        req_p = 8'h11;
        step();
        total++;
        if (gnt_p !== 8'h01) begin
            bad++;
            $display("FAIL rstmid_first got=%h need 01", gnt_p);
        end
        req_p = '0;
        step();
    endtask

    task automatic test_glitch();
        apply_reset();
        #1;
        req_p = 8'h04;
        req_s = 4'b1000;
        #1;
        req_p = 8'h00;
        req_s = 4'b0000;
        step();
        total++;
        if (gnt_p !== 8'h00 || {gnt_m, gnt_s} !== 5'h00) begin
            bad++;
            $display("FAIL glitch got=%h/%b need 00/00000",
                     gnt_p, {gnt_m, gnt_s});
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(3) == 0) req_p = 8'($urandom);
            if ($urandom_range(3) == 0) req_s = 4'($urandom);
            if ($urandom_range(3) == 0) req_m = 1'($urandom);
            rst = ($urandom_range(80) == 0);
            step();
            total++;
            if (gnt_p !== exp_p()) begin
                bad++;
                $display("FAIL rand_proc cyc=%0d got=%h need %h",
                         cyc, gnt_p, exp_p());
            end
            total++;
            if ({gnt_m, gnt_s} !== exp_s()) begin
                bad++;
                $display("FAIL rand_snoop cyc=%0d got=%b need %b",
                         cyc, {gnt_m, gnt_s}, exp_s());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        m_pown = -1;
        m_last = 7;
        m_sown = -1;
        rst    = 1'b1;
        req_p  = '0;
        req_s  = '0;
        req_m  = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_snoop_priority();
        test_concurrent();
        test_reset_mid();
        test_glitch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 Com_Bus_Req_proc_0 .. Com_Bus_Req_proc_7  in  1 each  processor-side cache requests for the common bus (miss/write-back traffic).
REQ-006 Com_Bus_Req_snoop_0 .. Com_Bus_Req_snoop_3  in  1 each  snoop-side cache requests to drive the common bus (snoop response, data supply).
REQ-007 Mem_snoop_req  in  1  memory request for the snoop-side bus.
REQ-008 Com_Bus_Gnt_proc_0 .. Com_Bus_Gnt_proc_7  out  1 each  processor-side grants.
REQ-009 Com_Bus_Gnt_snoop_0 .. Com_Bus_Gnt_snoop_3  out  1 each  snoop-side grants.
REQ-010 Mem_snoop_gnt  out  1  memory snoop-side grant.

Function
REQ-011 All grant outputs SHALL be registered, with no combinational path from any request to any grant.
REQ-012 The processor grant group SHALL be one-hot-or-zero in every cycle.
REQ-013 The snoop grant group (Com_Bus_Gnt_snoop_0..3 plus Mem_snoop_gnt) SHALL be one-hot-or-zero in every cycle.
REQ-014 The processor group and the snoop group SHALL be arbitrated independently, so one proc grant and one snoop-group grant may be high in the same cycle.
REQ-015 Processor arbiter states SHALL be: IDLE (no grant) and GRANT(n) (Com_Bus_Gnt_proc_n high).
REQ-016 IDLE -> GRANT(n): when at least one proc request is high at a rising edge, the grant SHALL assert for the winner n on that edge, so the grant is visible one cycle after the request is first sampled.
REQ-017 The proc winner SHALL be chosen round-robin: search starts at index (last_granted+1) mod 8 and wraps from 7 to 0; the pointer resets to 7 so that proc_0 wins first.
REQ-018 GRANT(n) SHALL be held while Com_Bus_Req_proc_n stays high, regardless of other requests (no preemption).
REQ-019 When Com_Bus_Req_proc_n is sampled low in GRANT(n), the grant SHALL drop on that edge and the state SHALL return to IDLE for one cycle; the next arbitration occurs on the following edge.
REQ-020 The snoop arbiter SHALL use the same IDLE/GRANT structure and release rules as the processor arbiter.
REQ-021 Snoop-group priority SHALL be fixed: snoop_0 > snoop_1 > snoop_2 > snoop_3 > Mem_snoop_req; memory is granted only when no cache snoop request is pending.
REQ-022 A held snoop-group grant SHALL NOT be preempted by a higher-priority request.
REQ-023 Requests that are raised and dropped between sampling edges SHALL be ignored.
REQ-024 If a request is asserted in the same cycle that another requester's grant is released, it SHALL be considered at the next arbitration edge, not the release edge.

Reset
REQ-025 While rst is sampled high, all grant outputs SHALL be 0, both arbiters SHALL be IDLE, and the proc round-robin pointer SHALL be 7.
REQ-026 A reset asserted mid-grant SHALL clear the grant on that edge, irrespective of request levels.
REQ-027 After rst deasserts, the first arbitration SHALL occur on the first rising edge with rst low.

Verification
REQ-028 Scenario single request: rst then Com_Bus_Req_proc_0=1 -> Com_Bus_Gnt_proc_0=1 next edge, held for 5 cycles while the request is held; request drops -> grant 0 next edge.
REQ-029 Scenario round-robin: proc_0, proc_3 and proc_7 held continuously, each requester dropping its request after 2 granted cycles and re-raising it -> grant order 0,3,7,0 with one IDLE cycle between grants.
REQ-030 Scenario snoop priority: snoop_2 and Mem_snoop_req raised together -> snoop_2 granted; snoop_0 raised while snoop_2 is granted -> no preemption; snoop_2 releases -> snoop_0 granted, then Mem_snoop_gnt once snoop_0 releases.
REQ-031 Scenario concurrent groups: proc_5 and snoop_1 raised together -> Com_Bus_Gnt_proc_5 and Com_Bus_Gnt_snoop_1 both assert on the same edge.
REQ-032 Scenario reset mid-operation: proc_4 granted, rst=1 for 1 cycle with request still high -> all grants 0; after rst low, proc_0 and proc_4 both requesting -> proc_0 granted first.
REQ-033 A checker SHALL confirm the one-hot-or-zero property of both groups on every clock edge in every scenario.
